// File: rtl/ts_sync_ctrl_if.sv
// Byte-stream bus between the TS capture stage, the sync controller and the packet store.
// master: the side that supplies input bytes and observes the forwarded stream and status.
// slave:  the sync controller itself.
interface ts_sync_ctrl_if #(
  parameter int unsigned CNT_WIDTH = 16
);

  logic [7:0]           ts_data;
  logic                 ts_valid;
  logic                 sink_ready;
  logic [7:0]           out_data;
  logic                 out_valid;
  logic                 out_sop;
  logic                 out_eop;
  logic                 locked;
  logic [CNT_WIDTH-1:0] pkt_count;
  logic [CNT_WIDTH-1:0] drop_count;
  logic [CNT_WIDTH-1:0] sync_err_count;

  modport master (
    output ts_data,
    output ts_valid,
    output sink_ready,
    input  out_data,
    input  out_valid,
    input  out_sop,
    input  out_eop,
    input  locked,
    input  pkt_count,
    input  drop_count,
    input  sync_err_count
  );

  modport slave (
    input  ts_data,
    input  ts_valid,
    input  sink_ready,
    output out_data,
    output out_valid,
    output out_sop,
    output out_eop,
    output locked,
    output pkt_count,
    output drop_count,
    output sync_err_count
  );

endinterface

// File: rtl/ts_sync_ctrl.sv
// MPEG-TS sync acquisition and packet gating.
// Hunts for the sync byte, confirms alignment over LOCK_COUNT packets, then forwards whole
// packets the sink accepted at their first byte. Output is registered: one clock of latency.
module ts_sync_ctrl #(
  parameter int unsigned PKT_LEN      = 188,
  parameter logic [7:0]  SYNC_BYTE    = 8'h47,
  parameter int unsigned LOCK_COUNT   = 3,
  parameter int unsigned UNLOCK_COUNT = 3,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input logic           clk,
  input logic           rst_n,
  ts_sync_ctrl_if.slave bus
);

  localparam int unsigned IW = $clog2(PKT_LEN);
  localparam int unsigned GW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MW = $clog2(UNLOCK_COUNT + 1);

  localparam logic [IW-1:0] LAST_IDX    = IW'(PKT_LEN - 1);
  localparam logic [GW-1:0] GOOD_LOCK   = GW'(LOCK_COUNT);
  localparam logic [MW-1:0] MISS_UNLOCK = MW'(UNLOCK_COUNT);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [GW-1:0]        good_q, good_d;
  logic [MW-1:0]        miss_q, miss_d;
  logic                 fwd_q, fwd_d;
  logic [7:0]           out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_sop_q, out_sop_d;
  logic                 out_eop_q, out_eop_d;
  logic [CNT_WIDTH-1:0] pkt_q, pkt_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic [CNT_WIDTH-1:0] err_q, err_d;

  logic          is_sync;
  logic          boundary;
  logic          last_byte;
  logic [IW-1:0] idx_inc;
  logic [GW-1:0] good_inc;
  logic [MW-1:0] miss_inc;
  logic          lock_confirm;
  logic          lock_boundary;
  logic          emit;

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign is_sync   = (bus.ts_data == SYNC_BYTE);
  assign boundary  = (idx_q == '0);
  assign last_byte = (idx_q == LAST_IDX);
  assign idx_inc   = last_byte ? '0 : idx_q + IW'(1);
  assign good_inc  = good_q + GW'(1);
  assign miss_inc  = miss_q + MW'(1);

  // The byte that confirms lock is handled exactly like a boundary seen while already locked.
  assign lock_confirm  = (state_q == ST_VERIFY) && boundary && is_sync && (good_inc == GOOD_LOCK);
  assign lock_boundary = bus.ts_valid && boundary &&
                         ((state_q == ST_LOCKED) || lock_confirm);

  // Next-state: alignment tracking, lock FSM, packet gating and statistics.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    good_d      = good_q;
    miss_d      = miss_q;
    fwd_d       = fwd_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_sop_d   = 1'b0;
    out_eop_d   = 1'b0;
    pkt_d       = pkt_q;
    drop_d      = drop_q;
    err_d       = err_q;
    emit        = 1'b0;

    if (bus.ts_valid) begin
      unique case (state_q)
        ST_HUNT: begin
          // Position is meaningless until a sync candidate is seen.
          if (is_sync) begin
            state_d = ST_VERIFY;
            idx_d   = IW'(1);
            good_d  = GW'(1);
          end
        end
        ST_VERIFY: begin
          idx_d = idx_inc;
          if (boundary) begin
            if (!is_sync) begin
              // Failed candidate; this byte is deliberately not re-tested as a new sync.
              state_d = ST_HUNT;
              idx_d   = '0;
              good_d  = '0;
            end else if (lock_confirm) begin
              state_d = ST_LOCKED;
              good_d  = '0;
            end else begin
              good_d = good_inc;
            end
          end
        end
        ST_LOCKED: begin
          idx_d = idx_inc;
          if (!boundary) begin
            emit = fwd_q;
          end
        end
        default: begin
          state_d = ST_HUNT;
          idx_d   = '0;
          good_d  = '0;
          miss_d  = '0;
          fwd_d   = 1'b0;
        end
      endcase

      // Forward/drop is decided here only and holds for the whole packet.
      if (lock_boundary) begin
        if (is_sync) begin
          miss_d = '0;
          fwd_d  = bus.sink_ready;
          emit   = bus.sink_ready;
          if (!bus.sink_ready) begin
            drop_d = sat_inc(drop_q);
          end
        end else begin
          fwd_d = 1'b0;
          err_d = sat_inc(err_q);
          if (miss_inc == MISS_UNLOCK) begin
            state_d = ST_HUNT;
            miss_d  = '0;
            idx_d   = '0;
          end else begin
            miss_d = miss_inc;
          end
        end
      end

      if (emit) begin
        out_valid_d = 1'b1;
        out_data_d  = bus.ts_data;
        out_sop_d   = boundary;
        out_eop_d   = last_byte;
        if (last_byte) begin
          pkt_d = sat_inc(pkt_q);
        end
      end
    end
  end

  // State and output registers; reset abandons any packet in flight without an EOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HUNT;
      idx_q       <= '0;
      good_q      <= '0;
      miss_q      <= '0;
      fwd_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      pkt_q       <= '0;
      drop_q      <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      good_q      <= good_d;
      miss_q      <= miss_d;
      fwd_q       <= fwd_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      pkt_q       <= pkt_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
    end
  end

  assign bus.out_data       = out_data_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_sop        = out_sop_q;
  assign bus.out_eop        = out_eop_q;
  assign bus.locked         = (state_q == ST_LOCKED);
  assign bus.pkt_count      = pkt_q;
  assign bus.drop_count     = drop_q;
  assign bus.sync_err_count = err_q;

endmodule

// File: doc/ts_sync_ctrl.md
# ts_sync_ctrl

Sync-acquisition and packet-gating controller for the MPEG-TS byte stream. It sits between the TS input capture stage and the packet store. It hunts for the 0x47 sync byte, confirms packet alignment over several packets, and tracks lock. It forwards only whole, sync-correct packets that the downstream sink can accept, and flags SOP/EOP, lock status and error statistics.

## Interface
Parameters:
- PKT_LEN, 188: bytes per TS packet (≥ 2).
- SYNC_BYTE, 8'h47: sync pattern.
- LOCK_COUNT, 3: consecutive aligned sync bytes needed to lock (≥ 2).
- UNLOCK_COUNT, 3: consecutive missed sync bytes that drop lock (≥ 1).
- CNT_WIDTH, 16: width of the statistics counters.

Ports:
- CLOCK, in, 1: single clock. All logic is on the rising edge.
- RESET_N, in, 1: reset, asynchronous, active-low.
- TS_DATA, in, 8: input byte.
- TS_VALID, in, 1: TS_DATA is valid this cycle.
- SINK_READY, in, 1: sink can take a full packet. Sampled only at packet start.
- OUT_DATA, out, 8: forwarded byte.
- OUT_VALID, out, 1: OUT_DATA is valid.
- OUT_SOP, out, 1: first byte (the sync byte) of a forwarded packet.
- OUT_EOP, out, 1: last byte of a forwarded packet.
- LOCKED, out, 1: high when the state is LOCKED.
- PKT_COUNT, out, CNT_WIDTH: packets forwarded.
- DROP_COUNT, out, CNT_WIDTH: packets dropped while locked.
- SYNC_ERR_COUNT, out, CNT_WIDTH: missed sync bytes while locked.

## Operation
- Only cycles with TS_VALID=1 are processed. With TS_VALID=0 all state holds and OUT_VALID=0.
- BYTE_IDX tracks the position in the packet, 0..PKT_LEN-1. It advances on each valid byte and wraps to 0 after PKT_LEN-1. "Boundary" means a valid byte with BYTE_IDX=0.
- States:
  - HUNT: BYTE_IDX is ignored. A valid byte equal to SYNC_BYTE moves to VERIFY, with BYTE_IDX=1 for the next byte and GOOD=1.
  - VERIFY: at a boundary:
    - If the byte is SYNC_BYTE, GOOD is incremented. When GOOD reaches LOCK_COUNT, the state becomes LOCKED and this byte is treated as a LOCKED boundary.
    - If the byte is not SYNC_BYTE, the state returns to HUNT. That byte is not re-tested as a sync candidate.
    - Nothing is forwarded in VERIFY.
  - LOCKED: at a boundary:
    - If the byte is SYNC_BYTE, MISS is cleared.
    - If SINK_READY=1, the packet is marked FORWARD. Otherwise it is marked DROP and DROP_COUNT is incremented.
    - If the byte is not SYNC_BYTE, MISS and SYNC_ERR_COUNT are incremented and the packet is marked DROP. DROP_COUNT is not incremented for this case.
    - If MISS reaches UNLOCK_COUNT, the state returns to HUNT, MISS is cleared, and the byte is not forwarded.
- FORWARD and DROP are decided only at the boundary. They hold for all PKT_LEN bytes of the packet, whatever SINK_READY does mid-packet.
- The lock-confirming packet is the first packet eligible for forwarding.
- Outputs for FORWARD packets:
  - OUT_DATA mirrors TS_DATA.
  - OUT_VALID is asserted for each byte.
  - OUT_SOP is asserted at BYTE_IDX=0.
  - OUT_EOP is asserted at BYTE_IDX=PKT_LEN-1.
- PKT_COUNT increments when OUT_EOP is issued.
- All counters saturate at all-ones and never wrap.
- Lock can only change at a boundary, so a forwarded packet is never truncated.

## Timing
- Reset (RESET_N low, asynchronous) forces:
  - the state to HUNT;
  - BYTE_IDX, GOOD and MISS to 0;
  - OUT_DATA to 0, and OUT_VALID, OUT_SOP, OUT_EOP and LOCKED to 0;
  - all counters to 0.
- Reset in the middle of a packet abandons the packet with no EOP. After release, the block re-hunts.
- Latency is exactly 1 clock. A byte accepted at edge n appears on OUT_* after edge n, i.e. it is registered and present for one cycle.
- LOCKED rises in the same cycle that the lock-confirming byte appears (or would appear, if dropped) on the output.
- LOCKED falls in the cycle after the UNLOCK_COUNT-th missed boundary byte.
- Gaps (TS_VALID=0) between bytes are allowed anywhere, including inside packets. They do not change the packet alignment.
- Minimum lock time: (LOCK_COUNT-1)·PKT_LEN+1 valid bytes from the first sync byte.

## Test plan
- Clean stream (0x47 every 188 bytes, continuous TS_VALID, SINK_READY=1): LOCKED rises with byte 376. First SOP is at byte 376. EOP is at byte 563. After 10 packets from lock, PKT_COUNT=10, DROP_COUNT=0, SYNC_ERR_COUNT=0.
- Random junk containing one isolated 0x47 at offset 5, with no sync at 193: the state goes HUNT→VERIFY→HUNT, LOCKED stays 0 and OUT_VALID is never asserted.
- Locked, then 3 consecutive boundary bytes set to 0x00: SYNC_ERR_COUNT=3, those 3 packets produce no output, and LOCKED falls after the third. Variant with only 2 bad boundaries then a good one: lock is kept and forwarding resumes.
- Locked, SINK_READY=0 at one boundary then 1 two bytes later: the whole packet is dropped, DROP_COUNT=1, and the next packet is forwarded intact.
- Locked stream with TS_VALID toggling 1/0 every cycle: output has identical SOP/EOP alignment, each byte is delayed exactly 1 cycle, and OUT_VALID is high on alternate cycles.
- RESET_N pulsed low at byte 100 of a forwarded packet: outputs go to 0 immediately with no EOP emitted. After release, lock is reacquired from the next sync bytes and PKT_COUNT restarts from 0.
